microwave_ctrl: RTL and testbench

Top-level controller for a microwave oven.
- Collects a 3-digit cooking time (M:SS) from a one-hot decimal keypad.
- Counts the time down at 1 Hz while the magnetron is on.
- Drives three 7-segment digit outputs.
- Runs from the 100 Hz system clock; sits directly between front-panel inputs and the display/magnetron drivers.

---
 rtl/microwave_pkg.sv | 36 +++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/microwave_ctrl.sv | 153 +++++++++++++++
 tb/tb_microwave_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared types, segment constants and keypad helpers for microwave_ctrl
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam int TICKS_PER_SEC_DEF = 100;

  function automatic logic is_onehot(input logic [9:0] k);
    return (k != 10'd0) && ((k & (k - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] key_to_digit(input logic [9:0] k);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) d = 4'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD digit to active-high {g,f,e,d,c,b,a} segments
module bcd_to_7seg
  import microwave_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/microwave_ctrl.sv
// rtl/microwave_ctrl.sv - microwave keypad entry, 1 Hz countdown and display; optional
// MICROWAVE_SEG_INV_EN inverts all segment outputs for common-anode displays.
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic [9:0] keys,
  output logic       mag_on,
  output logic [6:0] ssec_ones,
  output logic [6:0] ssec_tens,
  output logic [6:0] smin
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  state_t          state, state_n;
  logic [3:0]      min, tens, ones;
  logic [3:0]      min_n, tens_n, ones_n;
  logic [3:0]      dec_min, dec_tens, dec_ones;
  logic [TW-1:0]   tick, tick_n;

  // Two-stage capture: the first stage registers the pin, the pair yields a one-cycle press.
  logic            start_r, start_p, stop_r, stop_p;
  logic [9:0]      keys_r, keys_p;
  logic            start_press, stop_press, key_valid, tick_wrap, time_zero, dec_zero;
  logic [9:0]      key_rise;

  assign start_press = start_p & ~start_r;
  assign stop_press  = stop_p & ~stop_r;
  assign key_rise    = keys_r & ~keys_p;
  assign key_valid   = is_onehot(key_rise);
  assign tick_wrap   = (tick == TW'(TICKS_PER_SEC - 1));
  assign time_zero   = (min == 4'd0) && (tens == 4'd0) && (ones == 4'd0);
  assign dec_zero    = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      start_r <= 1'b0;
      start_p <= 1'b0;
      stop_r  <= 1'b0;
      stop_p  <= 1'b0;
      keys_r  <= 10'd0;
      keys_p  <= 10'd0;
    end else begin
      start_r <= startn;
      start_p <= start_r;
      stop_r  <= stopn;
      stop_p  <= stop_r;
      keys_r  <= keys;
      keys_p  <= keys_r;
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state <= IDLE;
      min   <= 4'd0;
      tens  <= 4'd0;
      ones  <= 4'd0;
      tick  <= '0;
    end else begin
      state <= state_n;
      min   <= min_n;
      tens  <= tens_n;
      ones  <= ones_n;
      tick  <= tick_n;
    end
  end

  // Tens above 5 are left as keyed; only a borrow reloads tens with 5.
  always_comb begin
    dec_min  = min;
    dec_tens = tens;
    dec_ones = ones;
    if (ones != 4'd0) begin
      dec_ones = ones - 4'd1;
    end else begin
      dec_ones = 4'd9;
      if (tens != 4'd0) begin
        dec_tens = tens - 4'd1;
      end else begin
        dec_tens = 4'd5;
        dec_min  = min - 4'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    min_n   = min;
    tens_n  = tens;
    ones_n  = ones;
    tick_n  = tick;
    case (state)
      IDLE, PAUSE: begin
        if (stop_press) begin
          state_n = IDLE;
          min_n   = 4'd0;
          tens_n  = 4'd0;
          ones_n  = 4'd0;
        end else if (start_press && door_closed && !time_zero) begin
          state_n = COOK;
          tick_n  = '0;
        end else if (key_valid) begin
          min_n  = tens;
          tens_n = ones;
          ones_n = key_to_digit(key_rise);
        end
      end
      COOK: begin
        if (tick_wrap) begin
          tick_n = '0;
          min_n  = dec_min;
          tens_n = dec_tens;
          ones_n = dec_ones;
        end else begin
          tick_n = tick + TW'(1);
        end
        if (tick_wrap && dec_zero) begin
          state_n = IDLE;
        end else if (stop_press || !door_closed) begin
          state_n = PAUSE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mag_on = (state == COOK);

  logic [6:0] raw_ones, raw_tens, raw_min;

  bcd_to_7seg u_seg_ones (.bcd(ones), .seg(raw_ones));
  bcd_to_7seg u_seg_tens (.bcd(tens), .seg(raw_tens));
  bcd_to_7seg u_seg_min  (.bcd(min),  .seg(raw_min));

`ifdef MICROWAVE_SEG_INV_EN
  assign ssec_ones = ~raw_ones;
  assign ssec_tens = ~raw_tens;
  assign smin      = ~raw_min;
`else
  assign ssec_ones = raw_ones;
  assign ssec_tens = raw_tens;
  assign smin      = raw_min;
`endif

endmodule

// File: tb/tb_microwave_ctrl.sv
// tb/tb_microwave_ctrl.sv - directed self-checking bench for microwave_ctrl
module tb_microwave_ctrl;

  logic       clock = 1'b0;
  logic       clearn, startn, stopn, door_closed;
  logic [9:0] keys;
  logic       mag_on;
  logic [6:0] ssec_ones, ssec_tens, smin;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  microwave_ctrl #(.TICKS_PER_SEC(100)) dut (
    .clock(clock), .clearn(clearn), .startn(startn), .stopn(stopn),
    .door_closed(door_closed), .keys(keys), .mag_on(mag_on),
    .ssec_ones(ssec_ones), .ssec_tens(ssec_tens), .smin(smin)
  );

  function automatic logic [6:0] sx(input logic [6:0] s);
`ifdef MICROWAVE_SEG_INV_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_key(input int d);
    keys = 10'd0;
    keys[d] = 1'b1;
    cyc(5);
    keys = 10'd0;
    cyc(15);
  endtask

  task automatic pulse_stop();
    stopn = 1'b0;
    cyc(3);
    stopn = 1'b1;
    cyc(2);
  endtask

  task automatic pulse_start();
    startn = 1'b0;
    cyc(3);
    startn = 1'b1;
    cyc(2);
  endtask

  task automatic chk_disp(input string nm, input logic [6:0] em, input logic [6:0] et,
                          input logic [6:0] eo);
    checks++;
    if ({smin, ssec_tens, ssec_ones} !== {sx(em), sx(et), sx(eo)}) begin
      $display("FAIL %s: display got %h %h %h want %h %h %h", nm, smin, ssec_tens, ssec_ones,
               sx(em), sx(et), sx(eo));
      errors++;
    end
  endtask

  task automatic chk_mag(input string nm, input logic e);
    checks++;
    if (mag_on !== e) begin
      $display("FAIL %s: mag_on got %b want %b", nm, mag_on, e);
      errors++;
    end
  endtask

  task automatic test_reset();
    clearn = 1'b0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1; keys = 10'd0;
    cyc(3);
    chk_mag("reset_mag", 1'b0);
    chk_disp("reset_disp", 7'h3F, 7'h3F, 7'h3F);
    clearn = 1'b1;
    cyc(50);
    chk_mag("idle_mag", 1'b0);
    chk_disp("idle_disp", 7'h3F, 7'h3F, 7'h3F);
  endtask

  task automatic test_key_entry();
    press_key(2);
    chk_disp("key_2", 7'h3F, 7'h3F, 7'h5B);
    press_key(0);
    press_key(0);
    chk_disp("key_200", 7'h5B, 7'h3F, 7'h3F);
    chk_mag("key_mag", 1'b0);
  endtask

  task automatic test_cook_start();
    startn = 1'b0;
    cyc(2);
    chk_mag("start_mag", 1'b1);
    cyc(3);
    startn = 1'b1;
    cyc(96);
    chk_disp("before_first_dec", 7'h5B, 7'h3F, 7'h3F);
    cyc(1);
    chk_disp("first_dec_159", 7'h06, 7'h6D, 7'h6F);
    chk_mag("cook_mag", 1'b1);
  endtask

  task automatic test_pause_resume();
    pulse_stop();
    chk_mag("pause_mag", 1'b0);
    cyc(150);
    chk_disp("pause_hold", 7'h06, 7'h6D, 7'h6F);
    startn = 1'b0;
    cyc(3);
    startn = 1'b1;
    cyc(1);
    chk_mag("resume_mag", 1'b1);
    cyc(98);
    chk_disp("resume_dec_158", 7'h06, 7'h6D, 7'h7F);
  endtask

  task automatic test_door();
    door_closed = 1'b0;
    cyc(2);
    chk_mag("door_open_mag", 1'b0);
    pulse_start();
    chk_mag("start_door_open", 1'b0);
    chk_disp("door_hold", 7'h06, 7'h6D, 7'h7F);
    door_closed = 1'b1;
    cyc(2);
    chk_mag("door_closed_no_start", 1'b0);
  endtask

  task automatic test_stop_clear();
    pulse_stop();
    chk_disp("pause_stop_clear", 7'h3F, 7'h3F, 7'h3F);
    chk_mag("pause_stop_mag", 1'b0);
  endtask

  task automatic test_multikey();
    keys = 10'b0000000101;
    cyc(5);
    keys = 10'd0;
    cyc(15);
    chk_disp("multikey_ignored", 7'h3F, 7'h3F, 7'h3F);
  endtask

  task automatic test_start_at_zero();
    pulse_start();
    cyc(5);
    chk_mag("start_zero_mag", 1'b0);
  endtask

  task automatic test_countdown();
    press_key(3);
    chk_disp("entry_003", 7'h3F, 7'h3F, 7'h4F);
    startn = 1'b0;
    cyc(2);
    chk_mag("cd_start_mag", 1'b1);
    cyc(3);
    startn = 1'b1;
    cyc(97);
    chk_disp("cd_002", 7'h3F, 7'h3F, 7'h5B);
    press_key(7);
    chk_disp("cook_key_ignored", 7'h3F, 7'h3F, 7'h5B);
    cyc(80);
    chk_disp("cd_001", 7'h3F, 7'h3F, 7'h06);
    cyc(99);
    chk_disp("cd_before_zero", 7'h3F, 7'h3F, 7'h06);
    chk_mag("cd_before_zero_mag", 1'b1);
    cyc(1);
    chk_disp("cd_000", 7'h3F, 7'h3F, 7'h3F);
    chk_mag("cd_zero_mag", 1'b0);
    cyc(98);
    chk_mag("cd_stay_idle", 1'b0);
  endtask

  task automatic test_tens_borrow();
    press_key(1);
    press_key(0);
    chk_disp("entry_010", 7'h3F, 7'h06, 7'h3F);
    startn = 1'b0;
    cyc(5);
    startn = 1'b1;
    cyc(97);
    chk_disp("borrow_009", 7'h3F, 7'h3F, 7'h6F);
    pulse_stop();
    pulse_stop();
    chk_disp("borrow_cleared", 7'h3F, 7'h3F, 7'h3F);
  endtask

  task automatic test_idle_stop();
    press_key(5);
    chk_disp("idle_entry_5", 7'h3F, 7'h3F, 7'h6D);
    pulse_stop();
    chk_disp("idle_stop_clear", 7'h3F, 7'h3F, 7'h3F);
    chk_mag("idle_stop_mag", 1'b0);
  endtask

  initial begin
    test_reset();
    test_key_entry();
    test_cook_start();
    test_pause_resume();
    test_door();
    test_stop_clear();
    test_multikey();
    test_start_at_zero();
    test_countdown();
    test_tens_borrow();
    test_idle_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
